// File: rtl/seq_multiplier_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared types and constants for the iterative shift-add multiplier.
//   mult_state_t : FSM encoding (IDLE, RUN, DONE)
//   MULT_W       : operand width (the fastadder fixes this at 16)
//   MULT_CYCLES  : number of shift-add iterations per product
// Helper functions cover two's-complement magnitude extraction and the two
// flavours of "product does not fit in MULT_W bits" detection.
// ---------------------------------------------------------------------------
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mult_state_t;

    localparam int MULT_W      = 16;
    localparam int MULT_CYCLES = 16;

    // Absolute value of a two's-complement operand. -32768 maps onto 0x8000,
    // which the unsigned datapath handles without any special case.
    function automatic logic [MULT_W-1:0] magnitude(input logic [MULT_W-1:0] v);
        return v[MULT_W-1] ? (~v + 1'b1) : v;
    endfunction

    // Unsigned: anything in the upper half means the result needs more bits.
    function automatic logic product_ovf_unsigned(input logic [2*MULT_W-1:0] p);
        return p[2*MULT_W-1:MULT_W] != '0;
    endfunction

    // Signed: the upper half must be a pure sign extension of bit MULT_W-1.
    function automatic logic product_ovf_signed(input logic [2*MULT_W-1:0] p);
        return p[2*MULT_W-1:MULT_W] != {MULT_W{p[MULT_W-1]}};
    endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// ---------------------------------------------------------------------------
// seq_multiplier_if
// Request/result bundle between the control unit and the multiplier.
//   start        : launch request, honoured only while busy is low
//   multiplicand : operand A, sampled when the request is accepted
//   multiplier   : operand B, sampled when the request is accepted
//   busy         : high while iterating
//   done         : one-cycle pulse, product/ovf valid
//   product      : 32-bit result, held until the next completion
//   ovf          : result does not fit in 16 bits
// Modports: master = control unit side, slave = multiplier side.
// ---------------------------------------------------------------------------
interface seq_multiplier_if;
    import mult_pkg::*;

    logic                  start;
    logic [MULT_W-1:0]     multiplicand;
    logic [MULT_W-1:0]     multiplier;
    logic                  busy;
    logic                  done;
    logic [2*MULT_W-1:0]   product;
    logic                  ovf;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product, ovf
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product, ovf
    );

endinterface

// File: rtl/seq_multiplier_fastadder.sv
// ---------------------------------------------------------------------------
// fastadder
// 16-bit adder built from four 4-bit carry-lookahead groups with a second
// lookahead level across the groups.
//   a, b     : addends
//   carryin  : carry into bit 0
//   sum      : a + b + carryin (low 16 bits)
//   carryout : carry out of bit 15
//   overflow : two's-complement overflow (carry into MSB xor carry out)
// ---------------------------------------------------------------------------
module fastadder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        carryin,
    output logic [15:0] sum,
    output logic        carryout,
    output logic        overflow
);

    logic [15:0] p;
    logic [15:0] g;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [4:0]  gc;
    logic [15:0] c;

    assign p = a ^ b;
    assign g = a & b;

    // Group generate/propagate for each nibble, the basis for the carries
    // that skip whole groups at once.
    always_comb begin
        grp_g = '0;
        grp_p = '0;
        for (int k = 0; k < 4; k++) begin
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p[k] = &p[4*k +: 4];
        end
    end

    // Group carries are each expanded from carryin directly, so none of them
    // waits on the group below.
    assign gc[0] = carryin;
    assign gc[1] = grp_g[0] | (grp_p[0] & carryin);
    assign gc[2] = grp_g[1] | (grp_p[1] & grp_g[0])
                 | (grp_p[1] & grp_p[0] & carryin);
    assign gc[3] = grp_g[2] | (grp_p[2] & grp_g[1])
                 | (grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[2] & grp_p[1] & grp_p[0] & carryin);
    assign gc[4] = grp_g[3] | (grp_p[3] & grp_g[2])
                 | (grp_p[3] & grp_p[2] & grp_g[1])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & carryin);

    // Inside a nibble the carry only travels three bits from its group carry.
    always_comb begin
        c = '0;
        for (int k = 0; k < 4; k++) begin
            c[4*k] = gc[k];
            for (int i = 0; i < 3; i++) begin
                c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
            end
        end
    end

    assign sum      = p ^ c;
    assign carryout = gc[4];
    assign overflow = c[15] ^ gc[4];

endmodule

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
// Iterative 16x16 shift-add multiplier. One fastadder adds the multiplicand
// into the upper accumulator half each RUN cycle; the {carry,sum,lower half}
// is then shifted right by one. Sixteen iterations plus one completion edge
// give done 17 cycles after the request is accepted.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; discards any in-flight product
//   bus   : seq_multiplier_if.slave (start/operands in, busy/done/product/ovf out)
// Parameters: WIDTH (operand width, only 16 legal), CYC_W (counter width).
// Build option: define MULT_SIGNED_EN for two's-complement operands; the
// default build is unsigned only with no sign logic.
// ---------------------------------------------------------------------------
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_W,
    parameter int CYC_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    seq_multiplier_if.slave  bus
);

    mult_state_t          state;
    mult_state_t          next_state;
    logic [CYC_W-1:0]     count;
    logic [WIDTH-1:0]     acc_hi;
    logic [WIDTH-1:0]     acc_lo;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     add_sum;
    logic                 add_carry;
    logic                 adder_ovf_unused;
    logic [WIDTH:0]       step_sum;
    logic                 accept;
    logic                 last_iter;
    logic [2*WIDTH-1:0]   raw_product;
    logic [2*WIDTH-1:0]   result;
    logic                 result_ovf;
    logic [WIDTH-1:0]     load_mcand;
    logic [WIDTH-1:0]     load_mult;
    logic [2*WIDTH-1:0]   product_q;
    logic                 ovf_q;
`ifdef MULT_SIGNED_EN
    logic                 neg_q;
`endif

    fastadder u_adder (
        .a        (acc_hi),
        .b        (mcand),
        .carryin  (1'b0),
        .sum      (add_sum),
        .carryout (add_carry),
        .overflow (adder_ovf_unused)
    );

    assign accept      = bus.start && (state != RUN);
    assign last_iter   = (count == CYC_W'(MULT_CYCLES));
    assign step_sum    = acc_lo[0] ? {add_carry, add_sum} : {1'b0, acc_hi};
    assign raw_product = {acc_hi, acc_lo};

`ifdef MULT_SIGNED_EN
    // The core always multiplies magnitudes; the sign is reapplied on completion.
    assign load_mcand = magnitude(bus.multiplicand);
    assign load_mult  = magnitude(bus.multiplier);
    assign result     = neg_q ? (~raw_product + 1'b1) : raw_product;
    assign result_ovf = product_ovf_signed(result);
`else
    assign load_mcand = bus.multiplicand;
    assign load_mult  = bus.multiplier;
    assign result     = raw_product;
    assign result_ovf = product_ovf_unsigned(result);
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A request is honoured from IDLE and from DONE, so
    // a held start chains operations back to back; RUN ignores start.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = RUN;
            RUN:     if (last_iter) next_state = DONE;
            DONE:    next_state = bus.start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: load on accept, one shift-add per RUN cycle, and capture the
    // product on the edge that leaves RUN once all iterations are in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            mcand     <= '0;
            product_q <= '0;
            ovf_q     <= 1'b0;
`ifdef MULT_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else if (accept) begin
            acc_hi <= '0;
            acc_lo <= load_mult;
            mcand  <= load_mcand;
            count  <= '0;
`ifdef MULT_SIGNED_EN
            neg_q  <= bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1];
`endif
        end else if (state == RUN) begin
            if (last_iter) begin
                product_q <= result;
                ovf_q     <= result_ovf;
            end else begin
                acc_hi <= step_sum[WIDTH:1];
                acc_lo <= {step_sum[0], acc_lo[WIDTH-1:1]};
                count  <= count + 1'b1;
            end
        end
    end

    assign bus.busy    = (state == RUN);
    assign bus.done    = (state == DONE);
    assign bus.product = product_q;
    assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
// Directed bench for seq_multiplier: reset values, latency, unsigned or
// signed products (follows MULT_SIGNED_EN), start ignored while busy,
// asynchronous reset mid-operation, and back-to-back operation.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;
    import mult_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    seq_multiplier_if mif();

    seq_multiplier dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif.slave)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Presents one request for a single cycle; returns on the falling edge
    // just after the accepting rising edge.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
        mif.start        = 1'b1;
        mif.multiplicand = a;
        mif.multiplier   = b;
        @(negedge clk);
        mif.start = 1'b0;
    endtask

    // Counts falling edges until done shows up, bounded so a dead DUT
    // still reaches the summary.
    task automatic waitDone(output int n);
        n = 0;
        while (mif.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic runOp(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp_p, input logic exp_ovf);
        int n;
        applyStimulus(a, b);
        waitDone(n);
        checkOutput({tag, " latency"}, n, 17);
        checkOutput({tag, " product"}, mif.product, exp_p);
        checkOutput({tag, " ovf"}, {31'd0, mif.ovf}, {31'd0, exp_ovf});
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int pulses;

        mif.start        = 1'b0;
        mif.multiplicand = '0;
        mif.multiplier   = '0;
        reset            = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset busy",    {31'd0, mif.busy}, 32'd0);
        checkOutput("reset done",    {31'd0, mif.done}, 32'd0);
        checkOutput("reset product", mif.product,       32'd0);
        checkOutput("reset ovf",     {31'd0, mif.ovf},  32'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] basic latency and product");
        runOp("100x100", 16'd100, 16'd100, 32'd10000, 1'b0);
        checkOutput("done pulse width", {31'd0, mif.done}, 32'd0);
        checkOutput("product held",     mif.product,       32'd10000);

`ifdef MULT_SIGNED_EN
        $display("[TB] signed products");
        runOp("-3x5",       16'hFFFD, 16'd5,    32'hFFFFFFF1, 1'b0);
        runOp("-32768x-1",  16'h8000, 16'hFFFF, 32'h00008000, 1'b1);
        runOp("-1x-1",      16'hFFFF, 16'hFFFF, 32'h00000001, 1'b0);
`else
        $display("[TB] unsigned products");
        runOp("ffffxffff",  16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1);
        runOp("8000x2",     16'h8000, 16'd2,    32'h00010000, 1'b1);
        runOp("00ffx0101",  16'h00FF, 16'h0101, 32'h0000FFFF, 1'b0);
`endif
        runOp("0x0",        16'd0,    16'd0,    32'd0,        1'b0);

        $display("[TB] start while busy is ignored");
        applyStimulus(16'd300, 16'd300);
        repeat (4) @(negedge clk);
        mif.start        = 1'b1;
        mif.multiplicand = 16'd999;
        mif.multiplier   = 16'd999;
        @(negedge clk);
        mif.start = 1'b0;
        checkOutput("ignored busy", {31'd0, mif.busy}, 32'd1);
        waitDone(n);
        checkOutput("ignored latency", 5 + n, 17);
        checkOutput("ignored product", mif.product, 32'd90000);
        checkOutput("ignored ovf", {31'd0, mif.ovf}, 32'd1);
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (mif.done === 1'b1) pulses++;
        end
        checkOutput("ignored extra done", pulses, 0);
        checkOutput("ignored idle busy", {31'd0, mif.busy}, 32'd0);
        checkOutput("ignored held product", mif.product, 32'd90000);

        $display("[TB] reset during RUN");
        applyStimulus(16'd200, 16'd300);
        repeat (7) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("midreset busy",    {31'd0, mif.busy}, 32'd0);
        checkOutput("midreset done",    {31'd0, mif.done}, 32'd0);
        checkOutput("midreset product", mif.product,       32'd0);
        checkOutput("midreset ovf",     {31'd0, mif.ovf},  32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        runOp("7x6", 16'd7, 16'd6, 32'd42, 1'b0);

        $display("[TB] back-to-back with start held");
        mif.start        = 1'b1;
        mif.multiplicand = 16'd3;
        mif.multiplier   = 16'd4;
        @(negedge clk);
        mif.multiplicand = 16'd0;
        mif.multiplier   = 16'd1234;
        waitDone(n);
        checkOutput("b2b first latency", n, 17);
        checkOutput("b2b first product", mif.product, 32'd12);
        @(negedge clk);
        mif.start = 1'b0;
        checkOutput("b2b reaccept busy", {31'd0, mif.busy}, 32'd1);
        n = 1;
        while (mif.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b2b cycles between done", n - 1, 17);
        checkOutput("b2b second product", mif.product, 32'd0);
        checkOutput("b2b second ovf", {31'd0, mif.ovf}, 32'd0);
        @(negedge clk);
        checkOutput("b2b final idle", {30'd0, mif.busy, mif.done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
